// File: rtl/fp_issue_seq_if.sv
// Decode-to-FP-sequencer bundle: FP decode info in, launch/stall/writeback controls out.
interface fp_issue_seq_if;
  logic       IsFpD;
  logic [1:0] FpOpD;
  logic [4:0] RdD;
  logic       FlushD;
  logic       FpStartE;
  logic [1:0] FpOpE;
  logic       StallF;
  logic       StallD;
  logic       FlushE;
  logic       FpBusy;
  logic       FpRegWriteW;
  logic [4:0] FpRdW;

  modport master (
    output IsFpD, FpOpD, RdD, FlushD,
    input  FpStartE, FpOpE, StallF, StallD, FlushE, FpBusy, FpRegWriteW, FpRdW
  );

  modport slave (
    input  IsFpD, FpOpD, RdD, FlushD,
    output FpStartE, FpOpE, StallF, StallD, FlushE, FpBusy, FpRegWriteW, FpRdW
  );
endinterface

// File: rtl/fp_issue_seq.sv
// Multi-cycle FP issue sequencer: launches an FP op, stalls the integer front end for the
// op's latency, then emits a one-cycle FP register writeback.
module fp_issue_seq #(
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 16,
  parameter int unsigned CNT_W   = 5
) (
  input logic           clk,
  input logic           reset,
  fp_issue_seq_if.slave bus
);

  typedef enum logic [1:0] {Idle = 2'd0, Exec = 2'd1, Wb = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fpOpE;
  logic [4:0]       fpRd;
  logic             fpStart;
  logic             stall;
  logic             regWrite;
  logic             issue;
  logic [CNT_W-1:0] cntLoad;

  // Counter is loaded with latency-1 so the Exec phase lasts exactly LAT cycles.
  always_comb begin
    cntLoad = '0;
    unique case (bus.FpOpD)
      2'b00, 2'b01: cntLoad = CNT_W'(LAT_ADD - 1);
      2'b10:        cntLoad = CNT_W'(LAT_MUL - 1);
      2'b11:        cntLoad = CNT_W'(LAT_DIV - 1);
      default:      cntLoad = '0;
    endcase
  end

  // Issue is possible from Wb too, giving back-to-back ops with no idle gap.
  assign issue = bus.IsFpD & ~bus.FlushD & ((state == Idle) | (state == Wb));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= Idle;
      cnt      <= '0;
      fpOpE    <= 2'b00;
      fpRd     <= 5'd0;
      fpStart  <= 1'b0;
      stall    <= 1'b0;
      regWrite <= 1'b0;
    end else begin
      fpStart  <= 1'b0;
      stall    <= 1'b0;
      regWrite <= 1'b0;
      case (state)
        Idle, Wb: begin
          if (issue) begin
            state   <= Exec;
            fpOpE   <= bus.FpOpD;
            fpRd    <= bus.RdD;
            cnt     <= cntLoad;
            fpStart <= 1'b1;
            stall   <= 1'b1;
          end else begin
            state <= Idle;
          end
        end
        Exec: begin
          if (cnt == '0) begin
            state    <= Wb;
            regWrite <= 1'b1;
          end else begin
            cnt   <= cnt - 1'b1;
            stall <= 1'b1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

  assign bus.FpStartE    = fpStart;
  assign bus.FpOpE       = fpOpE;
  assign bus.StallF      = stall;
  assign bus.StallD      = stall;
  assign bus.FlushE      = stall;
  assign bus.FpBusy      = (state != Idle);
  assign bus.FpRegWriteW = regWrite;
  assign bus.FpRdW       = fpRd;

endmodule
